// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared UART definitions, used by both the transmit and receive sides.
//   BIT_SAMPLING     : tick count of the last tick in a bit period (16x oversampling)
//   HALFBIT_SAMPLING : tick count at the middle of the start bit
//   rx_state_t       : receiver FSM states
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam logic [3:0] BIT_SAMPLING     = 4'd15;
    localparam logic [3:0] HALFBIT_SAMPLING = 4'd7;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } rx_state_t;

endpackage : uart_pkg

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Generic two-flop synchronizer for a single asynchronous input.
//   clk     : destination clock
//   arst_n  : asynchronous active-low reset; both flops load RST_VAL
//   d_i     : asynchronous input
//   q_o     : synchronized output, two clk cycles behind d_i
// -----------------------------------------------------------------------------
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic arst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value; blocking here would collapse the two stages.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule : sync_2ff

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// 8N1 (LSB-first, idle-high) UART receiver on a 16x oversampling tick.
// Validates the start bit at mid-bit, samples each data bit at mid-bit,
// checks the stop bit and hands bytes downstream over valid/ready.
//   clk        : system clock
//   arst_n     : asynchronous active-low reset
//   rx         : serial line, asynchronous to clk
//   tick       : 1-cycle strobe, 16 per bit period
//   rx_data    : received byte, stable while rx_valid is high
//   rx_valid   : holding register full
//   rx_ready   : consumer accepts on rx_valid && rx_ready
//   frame_err  : 1-cycle pulse, stop bit sampled low
//   overrun    : 1-cycle pulse, good byte dropped because holding register full
// -----------------------------------------------------------------------------
module uart_rx
    import uart_pkg::*;
#(
    parameter int BYTE_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  rx,
    input  logic                  tick,
    output logic [BYTE_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic                  frame_err,
    output logic                  overrun
);

    localparam int NB_W = (BYTE_WIDTH > 1) ? $clog2(BYTE_WIDTH) : 1;
    localparam logic [NB_W-1:0] LAST_BIT = NB_W'(BYTE_WIDTH - 1);

    logic rx_s;

    rx_state_t             state_q,     state_d;
    logic [3:0]            cnt_q,       cnt_d;
    logic [NB_W-1:0]       nbits_q,     nbits_d;
    logic [BYTE_WIDTH-1:0] shreg_q,     shreg_d;
    logic [BYTE_WIDTH-1:0] rx_data_q,   rx_data_d;
    logic                  rx_valid_q,  rx_valid_d;
    logic                  frame_err_q, frame_err_d;
    logic                  overrun_q,   overrun_d;

    sync_2ff #(
        .RST_VAL (1'b1)
    ) u_sync_rx (
        .clk    (clk),
        .arst_n (arst_n),
        .d_i    (rx),
        .q_o    (rx_s)
    );

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            nbits_q     <= '0;
            shreg_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            nbits_q     <= nbits_d;
            shreg_q     <= shreg_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    always_comb begin
        // NOTE: every signal gets a default before the case so that no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        nbits_d     = nbits_q;
        shreg_d     = shreg_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;

        // Consumption; a good frame finishing in the same cycle overrides it below.
        if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                cnt_d   = '0;
                nbits_d = '0;
                // Falling edge is taken immediately; mid-bit validation
                // happens in START.
                if (!rx_s) begin
                    state_d = START;
                end
            end

            START: begin
                if (tick) begin
                    if (cnt_q == HALFBIT_SAMPLING) begin
                        cnt_d   = '0;
                        state_d = rx_s ? IDLE : DATA;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end

            DATA: begin
                if (tick) begin
                    if (cnt_q == BIT_SAMPLING) begin
                        shreg_d = {rx_s, shreg_q[BYTE_WIDTH-1:1]};
                        cnt_d   = '0;
                        if (nbits_q == LAST_BIT) begin
                            nbits_d = '0;
                            state_d = STOP;
                        end else begin
                            nbits_d = nbits_q + 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end

            STOP: begin
                if (tick) begin
                    if (cnt_q == BIT_SAMPLING) begin
                        cnt_d = '0;
                        if (rx_s) begin
                            // Straight to IDLE so a start bit right after
                            // this stop bit is not missed.
                            state_d = IDLE;
                            if (!rx_valid_q || rx_ready) begin
                                rx_data_d  = shreg_q;
                                rx_valid_d = 1'b1;
                            end else begin
                                overrun_d = 1'b1;
                            end
                        end else begin
                            frame_err_d = 1'b1;
                            shreg_d     = '0;
                            state_d     = BREAK;
                        end
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end

            BREAK: begin
                // Wait out a held-low line instead of decoding it as 0x00 frames.
                if (rx_s) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule : uart_rx

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx
// Self-checking bench for uart_rx. A bit-level line model drives 8N1 frames,
// tick strobes every 4 clk, and a monitor collects accepted bytes and error
// pulses. Expected results come from the frame table, hand sequences and a
// queue model of "every good frame is delivered in order".
// -----------------------------------------------------------------------------
module tb_uart_rx;

    localparam int BIT_CLKS   = 64;   // 16 ticks * 4 clk
    localparam int STOP_TICK  = 152;  // stop-bit sample tick counted from START entry

    logic       clk;
    logic       arst_n;
    logic       rx;
    logic       tick;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_err;
    logic       overrun;

    uart_rx #(
        .BYTE_WIDTH (8)
    ) dut (
        .clk       (clk),
        .arst_n    (arst_n),
        .rx        (rx),
        .tick      (tick),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Tick strobe, changed on the falling edge so it is stable at each rising edge.
    logic [1:0] tdiv;
    initial begin
        tdiv = 2'd0;
        tick = 1'b0;
    end
    always @(negedge clk) begin
        tdiv = tdiv + 2'd1;
        tick = (tdiv == 2'd0);
    end

    // ------------------------------------------------------------------ monitor
    logic [7:0] got_q[$];
    int         n_ferr;
    int         n_ovr;
    int         n_tests;
    int         n_fail;

    initial begin
        n_ferr = 0;
        n_ovr  = 0;
    end

    always @(negedge clk) begin
        #1;
        if (arst_n) begin
            if (rx_valid && rx_ready) got_q.push_back(rx_data);
            if (frame_err)            n_ferr++;
            if (overrun)              n_ovr++;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Line model: call right after a falling clk edge; leaves rx at the stop value.
    task automatic send_frame(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        repeat (BIT_CLKS) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (BIT_CLKS) @(negedge clk);
        end
        rx = stop;
        repeat (BIT_CLKS) @(negedge clk);
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Raises rx_ready for exactly the cycle in which a frame started at the
    // same falling edge completes: rx_s lags rx by 2 clk, START is entered on
    // the third rising edge, then the stop bit is taken on its 152nd tick.
    task automatic accept_at_completion();
        int ticks;
        ticks = 0;
        repeat (3) @(posedge clk);
        while (ticks < STOP_TICK - 1) begin
            @(posedge clk);
            if (tick) ticks++;
        end
        repeat (4) @(negedge clk);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    // --------------------------------------------------------------- vectors
    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       exp_valid;
        logic       exp_ferr;
        logic [7:0] exp_data;
    } vec_t;

    vec_t tbl[6];

    // Global time bound.
    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1, "timeout");
    end

    initial begin
        int         g0;
        int         f0;
        int         o0;
        logic [7:0] exp_q[$];
        int         exp_ferr;

        n_tests  = 0;
        n_fail   = 0;
        rx       = 1'b1;
        rx_ready = 1'b1;
        arst_n   = 1'b0;

        tbl[0] = '{data: 8'hA5, stop: 1'b1, exp_valid: 1'b1, exp_ferr: 1'b0, exp_data: 8'hA5};
        tbl[1] = '{data: 8'h00, stop: 1'b1, exp_valid: 1'b1, exp_ferr: 1'b0, exp_data: 8'h00};
        tbl[2] = '{data: 8'hFF, stop: 1'b1, exp_valid: 1'b1, exp_ferr: 1'b0, exp_data: 8'hFF};
        tbl[3] = '{data: 8'h3C, stop: 1'b0, exp_valid: 1'b0, exp_ferr: 1'b1, exp_data: 8'h00};
        tbl[4] = '{data: 8'h81, stop: 1'b1, exp_valid: 1'b1, exp_ferr: 1'b0, exp_data: 8'h81};
        tbl[5] = '{data: 8'h7E, stop: 1'b0, exp_valid: 1'b0, exp_ferr: 1'b1, exp_data: 8'h00};

        // ---- reset state
        repeat (5) @(negedge clk);
        #1;
        check("reset rx_data",   32'(rx_data),   32'h0);
        check("reset rx_valid",  32'(rx_valid),  32'h0);
        check("reset frame_err", 32'(frame_err), 32'h0);
        check("reset overrun",   32'(overrun),   32'h0);
        @(negedge clk);
        arst_n = 1'b1;
        idle(20);

        // ---- table-driven single frames with rx_ready=1
        for (int i = 0; i < 6; i++) begin
            g0 = got_q.size();
            f0 = n_ferr;
            o0 = n_ovr;
            send_frame(tbl[i].data, tbl[i].stop);
            idle(100);
            check($sformatf("tbl%0d valid count", i), 32'(got_q.size() - g0), 32'(tbl[i].exp_valid));
            check($sformatf("tbl%0d frame_err count", i), 32'(n_ferr - f0), 32'(tbl[i].exp_ferr));
            check($sformatf("tbl%0d overrun count", i), 32'(n_ovr - o0), 32'h0);
            if (tbl[i].exp_valid)
                check($sformatf("tbl%0d data", i),
                      32'((got_q.size() > g0) ? got_q[g0] : 8'hxx), 32'(tbl[i].exp_data));
        end

        // ---- glitch: low for 3 ticks, then high
        g0 = got_q.size();
        f0 = n_ferr;
        rx = 1'b0;
        repeat (12) @(negedge clk);
        idle(200);
        check("glitch no valid", 32'(got_q.size() - g0), 32'h0);
        check("glitch no frame_err", 32'(n_ferr - f0), 32'h0);
        send_frame(8'h3C, 1'b1);
        idle(100);
        check("after glitch count", 32'(got_q.size() - g0), 32'h1);
        check("after glitch data", 32'((got_q.size() > g0) ? got_q[g0] : 8'hxx), 32'h3C);

        // ---- framing error then long held-low line
        g0 = got_q.size();
        f0 = n_ferr;
        send_frame(8'h3C, 1'b0);
        repeat (800) @(negedge clk);   // rx still low
        #1;
        check("break single frame_err", 32'(n_ferr - f0), 32'h1);
        check("break no valid", 32'(got_q.size() - g0), 32'h0);
        check("break rx_valid low", 32'(rx_valid), 32'h0);
        @(negedge clk);
        idle(100);
        send_frame(8'h81, 1'b1);
        idle(100);
        check("after break count", 32'(got_q.size() - g0), 32'h1);
        check("after break data", 32'((got_q.size() > g0) ? got_q[g0] : 8'hxx), 32'h81);
        check("after break frame_err", 32'(n_ferr - f0), 32'h1);

        // ---- overrun: two back-to-back frames with rx_ready=0
        rx_ready = 1'b0;
        g0 = got_q.size();
        o0 = n_ovr;
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        idle(100);
        #1;
        check("overrun rx_valid", 32'(rx_valid), 32'h1);
        check("overrun rx_data kept", 32'(rx_data), 32'h11);
        check("overrun pulse count", 32'(n_ovr - o0), 32'h1);
        @(negedge clk);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        #2;
        check("overrun consume count", 32'(got_q.size() - g0), 32'h1);
        check("overrun consume data", 32'((got_q.size() > g0) ? got_q[g0] : 8'hxx), 32'h11);
        check("overrun rx_valid falls", 32'(rx_valid), 32'h0);
        check("rx_data held after consume", 32'(rx_data), 32'h11);
        @(negedge clk);

        // ---- simultaneous accept while a byte is held
        send_frame(8'h44, 1'b1);
        idle(100);
        g0 = got_q.size();
        o0 = n_ovr;
        fork
            send_frame(8'h55, 1'b1);
            accept_at_completion();
        join_any
        // accept_at_completion ends first, one cycle after the accept edge.
        #2;
        check("simul rx_valid stays", 32'(rx_valid), 32'h1);
        check("simul rx_data new", 32'(rx_data), 32'h55);
        check("simul consumed old", 32'((got_q.size() > g0) ? got_q[g0] : 8'hxx), 32'h44);
        check("simul consume count", 32'(got_q.size() - g0), 32'h1);
        check("simul no overrun", 32'(n_ovr - o0), 32'h0);
        wait fork;
        idle(100);

        // ---- reset in the middle of data bit 4 of 0xF0, with 0x55 still held
        rx = 1'b0;
        repeat (BIT_CLKS * 5) @(negedge clk);   // start + data bits 0..3 (all 0)
        rx = 1'b1;                              // bit 4
        repeat (BIT_CLKS / 2) @(negedge clk);
        arst_n = 1'b0;
        #1;
        check("midreset rx_data", 32'(rx_data), 32'h0);
        check("midreset rx_valid", 32'(rx_valid), 32'h0);
        check("midreset frame_err", 32'(frame_err), 32'h0);
        check("midreset overrun", 32'(overrun), 32'h0);
        repeat (10) @(negedge clk);
        arst_n = 1'b1;
        rx_ready = 1'b1;
        idle(100);
        g0 = got_q.size();
        f0 = n_ferr;
        send_frame(8'h5A, 1'b1);
        idle(100);
        check("after reset count", 32'(got_q.size() - g0), 32'h1);
        check("after reset data", 32'((got_q.size() > g0) ? got_q[g0] : 8'hxx), 32'h5A);
        check("after reset frame_err", 32'(n_ferr - f0), 32'h0);

        // ---- randomized frames against the delivery model
        g0 = got_q.size();
        f0 = n_ferr;
        o0 = n_ovr;
        exp_ferr = 0;
        for (int i = 0; i < 20; i++) begin
            logic [7:0] b;
            logic       good;
            b    = 8'($urandom_range(0, 255));
            good = ($urandom_range(0, 3) != 0);
            send_frame(b, good);
            if (good) begin
                exp_q.push_back(b);
                idle($urandom_range(0, 40));   // 0 gives a back-to-back frame
            end else begin
                exp_ferr++;
                idle($urandom_range(20, 60));
            end
        end
        idle(100);
        check("rand byte count", 32'(got_q.size() - g0), 32'(exp_q.size()));
        check("rand frame_err count", 32'(n_ferr - f0), 32'(exp_ferr));
        check("rand overrun count", 32'(n_ovr - o0), 32'h0);
        for (int i = 0; i < exp_q.size(); i++) begin
            check($sformatf("rand byte %0d", i),
                  32'((got_q.size() > g0 + i) ? got_q[g0 + i] : 8'hxx), 32'(exp_q[i]));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_uart_rx

// File: doc/uart_rx.md
# uart_rx

UART receive stage that deserializes the line driven by the team's UART transmitter (8N1, LSB first, idle-high) into parallel bytes. It shares the same 16x oversampling `tick` from the baud-rate generator as the transmit side. It validates the start bit at mid-bit, samples each data bit at mid-bit and checks the stop bit. It hands completed bytes to the downstream consumer (command decoder / register loader) over a valid/ready handshake.

## Interface
- `BYTE_WIDTH`, default 8: data bits per frame.
- `clk`  in  1  system clock.
- `arst_n`  in  1  reset; asynchronous, active-low.
- `rx`  in  1  serial line from the transmitter `tx`; asynchronous to `clk`.
- `tick`  in  1  1-cycle strobe, 16 per bit period.
- `rx_data`  out  BYTE_WIDTH  received byte; stable while `rx_valid`=1.
- `rx_valid`  out  1  byte available.
- `rx_ready`  in  1  consumer accepts; the transfer occurs on a cycle with `rx_valid`&&`rx_ready`.
- `frame_err`  out  1  1-cycle pulse: stop bit sampled 0.
- `overrun`  out  1  1-cycle pulse: byte completed while the holding register was full and not being accepted.

## Operation
- **Synchronizer:** `rx` passes through a 2-FF synchronizer to give `rx_s`. Both flops reset to 1. All FSM decisions use `rx_s`.
- **IDLE:** `cnt`=0, `nbits`=0. `rx_s`=0 moves to START on the next edge; this does not wait for `tick`.
- **START:** on each `tick`, `cnt`++. When `cnt`==7 on a `tick`:
  - `rx_s`=0: `cnt`=0, go to DATA.
  - `rx_s`=1: glitch, return to IDLE. No outputs change.
- **DATA:** on `tick` with `cnt`==15:
  - `shreg` = {`rx_s`, `shreg`[BYTE_WIDTH-1:1]}, so the byte is assembled LSB first.
  - `cnt`=0.
  - If `nbits`==BYTE_WIDTH-1, go to STOP; otherwise `nbits`++.
  - On other ticks, `cnt`++.
- **STOP:** on `tick` with `cnt`==15, sample `rx_s`:
  - `rx_s`=1: the frame is good. Deliver per the holding rules below, then go to IDLE.
  - `rx_s`=0: pulse `frame_err`, discard `shreg`, go to BREAK.
- **BREAK:** stay until `rx_s`=1, then go to IDLE. This prevents a held-low line from being decoded as a stream of 0x00 frames.
- **Holding register rules on a good frame:**
  - `rx_valid`=0: load `rx_data`=`shreg`, set `rx_valid`=1.
  - `rx_valid`=1 and `rx_ready`=1 in the same cycle: load the new byte, `rx_valid` stays 1, no overrun.
  - `rx_valid`=1 and `rx_ready`=0: keep the old byte, drop the new one, pulse `overrun`.
- **Handshake:**
  - `rx_valid`&&`rx_ready` with no frame completing clears `rx_valid` on the next edge.
  - `rx_data` holds its last value after it is consumed.
- **Counter widths:** `cnt` is 4 bits and `nbits` is $clog2(BYTE_WIDTH) bits. Neither wraps in normal use; they are reset explicitly at each transition.
- **Ticks only:** `cnt` and `nbits` change only on `tick`. The exceptions are explicit zeroing on entering START and on entering IDLE.

## Timing
- **Reset values:**
  - Outputs: `rx_data`=0, `rx_valid`=0, `frame_err`=0, `overrun`=0.
  - Internal: state=IDLE, `cnt`=0, `nbits`=0, `shreg`=0, synchronizer=1.
- **Reset mid-frame:** asserting `arst_n` during a frame aborts it immediately and discards the partial byte.
- **Input latency:** 2 clk from an `rx` edge to `rx_s`.
- **Sample points, counted in ticks from START entry:**
  - Start bit validated at tick 8.
  - Data bit k sampled at tick 8+16(k+1).
  - Stop bit sampled at tick 8+16(BYTE_WIDTH+1), which is 152 for 8 bits.
- **Output timing:** `rx_valid`, `frame_err` and `overrun` assert on the clk edge following the stop-bit sampling tick.
- **Back-to-back frames:** IDLE is entered in the same cycle the stop is accepted, so a start bit immediately following the stop bit is caught.

## Structure
- **`uart_pkg`** (shared with the transmitter) holds:
  - `BIT_SAMPLING`=15 and `HALFBIT_SAMPLING`=7.
  - `rx_state_t` enum {IDLE, START, DATA, STOP, BREAK}, 3 bits.
- **`sync_2ff`:** one sub-module, a generic 2-flop synchronizer with a reset-value parameter (1 here). It is reusable for other asynchronous inputs.

## Test plan
Bench conditions: `tick` every 4 clk; frames driven by the team's transmitter or by a bit-level model.

- **Single byte:** send 0xA5 with `rx_ready`=1 → `rx_valid` pulses one cycle with `rx_data`=0xA5; `frame_err`=0 and `overrun`=0 throughout.
- **Glitch rejection:** hold `rx` low for 3 ticks, then high → FSM returns to IDLE; no `rx_valid`, no `frame_err`. A following 0x3C is received as 0x3C.
- **Framing error:** send 0x3C with stop bit=0, then hold `rx` low for 40 ticks, then release → one `frame_err` pulse, `rx_valid` stays 0, FSM stays in BREAK until `rx` goes high. The next frame 0x81 is received correctly.
- **Overrun:** send 0x11 then 0x22 back-to-back with `rx_ready`=0 → `rx_data`=0x11 retained and one `overrun` pulse at the end of the 0x22 frame. Asserting `rx_ready` then consumes 0x11 and `rx_valid` falls.
- **Simultaneous accept:** assert `rx_ready` exactly in the cycle the 0x55 frame completes while 0x44 is held → 0x44 consumed, `rx_data`=0x55, `rx_valid` stays 1, no `overrun`.
- **Reset mid-frame:** assert `arst_n`=0 during data bit 4 of 0xF0 → all outputs return to reset values. After release with `rx` idle-high, 0x5A is received correctly.
